// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Stall / bubble / flush sequencing for the 5-stage MIPS pipeline. Merges the
// ID-stage load-use check, an ID-stage taken branch and multi-cycle MEM-stage
// data accesses into PC, IF/ID, ID/EX-select and whole-pipe freeze controls.
// Optional feature: define STALL_COUNTER_EN to add the saturating stall_count
// output and its register.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal flow; a multi-cycle memory access freezes and leaves RUN
// WAIT  | memory access still busy; pipe held, wcnt counts down to 1
// DONE  | last cycle of the access; pipe moves, access input ignored

module pipeline_stall_controller #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_mem_read,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             EXMEM_mem_access,
  input  logic             branch_taken,
  output logic             pc_load,
  output logic             IFID_Ld,
  output logic             IFID_flush,
  output logic             sel_signal,
  output logic             pipe_freeze
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam bit MULTI_CYCLE = (MEM_LAT > 1);
  localparam bit NEEDS_WAIT  = (MEM_LAT > 2);
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 2);

  // Reject illegal parameter values at elaboration time.
  if (MEM_LAT < 1 || MEM_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_stall_controller: MEM_LAT must be 1..15 and CNT_W >= 1");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       freeze;
  logic       load_use;

  // Hazard conditions; register 0 deliberately gets no special treatment.
  always_comb begin
    freeze   = ((state_q == ST_RUN) && EXMEM_mem_access && MULTI_CYCLE) ||
               (state_q == ST_WAIT);
    load_use = IDEX_mem_read && ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  end

  // Mealy outputs with priority freeze > load-use > branch; reset forces all low.
  always_comb begin
    pc_load     = 1'b1;
    IFID_Ld     = 1'b1;
    IFID_flush  = 1'b0;
    sel_signal  = 1'b1;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_load    = 1'b0;
      IFID_Ld    = 1'b0;
      sel_signal = 1'b0;
    end else if (freeze) begin
      pc_load     = 1'b0;
      IFID_Ld     = 1'b0;
      pipe_freeze = 1'b1;
    end else if (load_use) begin
      pc_load    = 1'b0;
      IFID_Ld    = 1'b0;
      sel_signal = 1'b0;
    end else if (branch_taken) begin
      IFID_flush = 1'b1;
    end
  end

  // Next-state and memory-latency down-counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (EXMEM_mem_access && MULTI_CYCLE) begin
          if (NEEDS_WAIT) begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd1) begin
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_load && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller. Four instances with
// MEM_LAT = 2, 3, 5, 1 share one input stimulus; each step pushes expected
// output vectors {pc_load, IFID_Ld, IFID_flush, sel_signal, pipe_freeze}.

module tb_pipeline_stall_controller;

  localparam int LATS [4] = '{2, 3, 5, 1};

  localparam logic [4:0] RST = 5'b00000;
  localparam logic [4:0] DEF = 5'b11010;
  localparam logic [4:0] LU  = 5'b00000;
  localparam logic [4:0] BR  = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] idex_rt = 5'd0;
  logic [4:0] ifid_rs = 5'd0;
  logic [4:0] ifid_rt = 5'd0;
  logic       mem_acc = 1'b0;
  logic       br = 1'b0;

  logic [4:0] outs [4];
  logic [1:0] cnts [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    logic pc_load, ifid_ld, ifid_flush, sel_signal, pipe_freeze;
    pipeline_stall_controller #(.MEM_LAT(LATS[k]), .CNT_W(2)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .IDEX_mem_read    (mem_read),
      .IDEX_Rt          (idex_rt),
      .IFID_Rs          (ifid_rs),
      .IFID_Rt          (ifid_rt),
      .EXMEM_mem_access (mem_acc),
      .branch_taken     (br),
      .pc_load          (pc_load),
      .IFID_Ld          (ifid_ld),
      .IFID_flush       (ifid_flush),
      .sel_signal       (sel_signal),
      .pipe_freeze      (pipe_freeze)
`ifdef STALL_COUNTER_EN
      ,
      .stall_count      (cnts[k])
`endif
    );
    assign outs[k] = {pc_load, ifid_ld, ifid_flush, sel_signal, pipe_freeze};
`ifndef STALL_COUNTER_EN
    assign cnts[k] = 2'd0;
`endif
  end

  typedef struct {
    int         d;     // instance index, or -1 for stall_count of instance 0
    logic [4:0] e;
    string      tag;
  } sb_t;

  sb_t sb [$];
  int  total  = 0;
  int  passed = 0;
  int  fails  = 0;

  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic acc, input logic b);
    mem_read = mr;
    idex_rt  = irt;
    ifid_rs  = rs;
    ifid_rt  = rt;
    mem_acc  = acc;
    br       = b;
  endtask

  task automatic exp_o(input int d, input logic [4:0] e, input string tag);
    sb.push_back('{d, e, tag});
  endtask

  task automatic exp_all(input logic [4:0] e, input string tag);
    for (int k = 0; k < 4; k++) exp_o(k, e, tag);
  endtask

  task automatic compare_all();
    sb_t        it;
    logic [4:0] obs;
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = (it.d < 0) ? {3'b000, cnts[0]} : outs[it.d];
      total++;
      assert (obs === it.e) passed++;
      else begin
        fails++;
        $error("FAIL %s inst%0d observed=%b expected=%b", it.tag, it.d, obs, it.e);
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check_cnt(input logic [1:0] c, input string tag);
`ifdef STALL_COUNTER_EN
    exp_o(-1, {3'b000, c}, tag);
    compare_all();
`else
    if (c === 2'bxx) exp_o(-1, 5'd0, tag);
`endif
  endtask

  initial begin
    // Reset held: all outputs low.
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    exp_all(RST, "reset");
    compare_all();
    rst = 1'b0;
    next_cycle();
    exp_all(DEF, "idle");
    compare_all();
    next_cycle();

    // Load-use variants; also the saturating stall counter (CNT_W=2).
    drive(1, 5, 5, 0, 0, 0); exp_all(LU, "lu_rs");    compare_all(); next_cycle(); check_cnt(2'd1, "cnt1");
    drive(1, 5, 6, 5, 0, 0); exp_all(LU, "lu_rt");    compare_all(); next_cycle(); check_cnt(2'd2, "cnt2");
    drive(1, 0, 0, 3, 0, 0); exp_all(LU, "lu_r0");    compare_all(); next_cycle(); check_cnt(2'd3, "cnt3");
    drive(1, 5, 5, 0, 0, 1); exp_all(LU, "lu_br");    compare_all(); next_cycle(); check_cnt(2'd3, "cnt_sat1");
    drive(1, 5, 5, 0, 0, 0); exp_all(LU, "lu_again"); compare_all(); next_cycle(); check_cnt(2'd3, "cnt_sat2");
    drive(1, 5, 6, 7, 0, 0); exp_all(DEF, "no_lu");      compare_all(); next_cycle();
    drive(0, 5, 5, 5, 0, 0); exp_all(DEF, "lu_no_load"); compare_all(); next_cycle();

    // Taken branch alone flushes for one cycle.
    drive(0, 0, 1, 2, 0, 1); exp_all(BR, "branch");      compare_all(); next_cycle();
    drive(0, 0, 1, 2, 0, 0); exp_all(DEF, "branch_end"); compare_all(); next_cycle();

    // Memory access held three cycles.
    drive(0, 0, 1, 2, 1, 0);
    exp_o(0, FRZ, "m1_lat2"); exp_o(1, FRZ, "m1_lat3_run"); exp_o(2, FRZ, "m1_lat5"); exp_o(3, DEF, "m1_lat1");
    compare_all(); next_cycle();
    exp_o(0, DEF, "m2_lat2_done"); exp_o(1, FRZ, "m2_lat3_wait"); exp_o(2, FRZ, "m2_lat5");
    compare_all(); next_cycle();
    exp_o(0, FRZ, "m3_lat2_b2b"); exp_o(1, DEF, "m3_lat3_done"); exp_o(2, FRZ, "m3_lat5");
    compare_all(); next_cycle();
    drive(0, 0, 1, 2, 0, 0);
    exp_o(0, DEF, "m4_lat2_done"); exp_o(1, DEF, "m4_lat3_run"); exp_o(2, FRZ, "m4_lat5_wait");
    compare_all(); next_cycle();
    exp_o(2, DEF, "m5_lat5_done"); compare_all(); next_cycle();
    exp_all(DEF, "m6_all_run");    compare_all(); next_cycle();

    // Access + load-use + branch together, then the bubble in DONE.
    drive(1, 5, 5, 0, 1, 1);
    exp_o(0, FRZ, "c1_lat2_frz"); exp_o(1, FRZ, "c1_lat3"); exp_o(2, FRZ, "c1_lat5"); exp_o(3, LU, "c1_lat1_lu");
    compare_all(); next_cycle();
    exp_o(0, LU, "c2_lat2_done_lu"); exp_o(1, FRZ, "c2_lat3_wait"); exp_o(2, FRZ, "c2_lat5_wait");
    compare_all(); next_cycle();
    drive(0, 0, 1, 2, 0, 0);
    exp_o(0, DEF, "c3_lat2"); exp_o(1, DEF, "c3_lat3_done"); exp_o(2, FRZ, "c3_lat5_wait");
    compare_all();

    // Asynchronous reset in the middle of WAIT.
    rst = 1'b1;
    exp_all(RST, "rst_async");
    compare_all();
    check_cnt(2'd0, "cnt_rst");
    next_cycle();
    rst = 1'b0;
    exp_all(DEF, "after_rst");
    compare_all();
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
